rtc_bus_sched: RTL and testbench

Scheduler that sequences all register traffic to the external RTC bus driver. It arbitrates between periodic refresh reads and user-commit writes coming from the time/date entry logic. It serialises each request into a burst of single-register bus transactions and returns read results as a coherent register set. It sits between the data-entry/display logic and the low-level RTC bus driver.

---
 rtl/rtc_bus_sched.sv | 224 ++++++++++++++++++++++
 tb/tb_rtc_bus_sched.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_sched.sv
// Sequences refresh reads and commit writes to the RTC bus driver, one register per transaction.
// Optional macro RTC_XFER_CMD_EN adds a latch (read) / commit (write) command transaction per burst.
module rtc_bus_sched #(
    parameter int N_REGS = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_lectura,
    input  logic       escribe_req,
    input  logic [7:0] wr_seg_C,
    input  logic [7:0] wr_min_C,
    input  logic [7:0] wr_hora_C,
    input  logic [7:0] wr_dia,
    input  logic [7:0] wr_mes,
    input  logic [7:0] wr_ano,
    input  logic [7:0] wr_seg_T,
    input  logic [7:0] wr_min_T,
    input  logic [7:0] wr_hora_T,
    input  logic       bus_done,
    input  logic [7:0] bus_rdata,
    output logic       bus_start,
    output logic       bus_rw,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic [7:0] rd_seg_C,
    output logic [7:0] rd_min_C,
    output logic [7:0] rd_hora_C,
    output logic [7:0] rd_dia,
    output logic [7:0] rd_mes,
    output logic [7:0] rd_ano,
    output logic [7:0] rd_seg_T,
    output logic [7:0] rd_min_T,
    output logic [7:0] rd_hora_T,
    output logic       rd_valid,
    output logic       wr_done,
    output logic       busy
);
    localparam logic [3:0] LAST = 4'(N_REGS - 1);

`ifdef RTC_XFER_CMD_EN
    typedef enum logic [2:0] {IDLE, CMD, ISSUE, WAIT, NEXT, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} state_t;
`endif

    state_t     state, state_n;
    logic       pend_rd, pend_wr, is_wr;
    logic       leave_rd, leave_wr, op_wr;
    logic [3:0] idx, load_idx;
    logic [7:0] wr_in  [9];
    logic [7:0] snap   [9];
    logic [7:0] shadow [9];
    logic [7:0] rd_q   [9];
`ifdef RTC_XFER_CMD_EN
    logic       cmd_phase;
`endif

    function automatic logic [7:0] reg_addr(input logic [3:0] i);
        case (i)
            4'd0: reg_addr = 8'h21;
            4'd1: reg_addr = 8'h22;
            4'd2: reg_addr = 8'h23;
            4'd3: reg_addr = 8'h24;
            4'd4: reg_addr = 8'h25;
            4'd5: reg_addr = 8'h26;
            4'd6: reg_addr = 8'h41;
            4'd7: reg_addr = 8'h42;
            4'd8: reg_addr = 8'h43;
            default: reg_addr = 8'h00;
        endcase
    endfunction

    assign wr_in[0] = wr_seg_C;
    assign wr_in[1] = wr_min_C;
    assign wr_in[2] = wr_hora_C;
    assign wr_in[3] = wr_dia;
    assign wr_in[4] = wr_mes;
    assign wr_in[5] = wr_ano;
    assign wr_in[6] = wr_seg_T;
    assign wr_in[7] = wr_min_T;
    assign wr_in[8] = wr_hora_T;

    assign rd_seg_C  = rd_q[0];
    assign rd_min_C  = rd_q[1];
    assign rd_hora_C = rd_q[2];
    assign rd_dia    = rd_q[3];
    assign rd_mes    = rd_q[4];
    assign rd_ano    = rd_q[5];
    assign rd_seg_T  = rd_q[6];
    assign rd_min_T  = rd_q[7];
    assign rd_hora_T = rd_q[8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        leave_rd = 1'b0;
        leave_wr = 1'b0;
        load_idx = idx;
        case (state)
            IDLE: begin
                load_idx = 4'd0;
                // Write wins so a commit is never delayed behind a refresh.
                if (pend_wr) begin
                    leave_wr = 1'b1;
                    state_n  = ISSUE;
                end else if (pend_rd) begin
                    leave_rd = 1'b1;
`ifdef RTC_XFER_CMD_EN
                    state_n  = CMD;
`else
                    state_n  = ISSUE;
`endif
                end
            end
`ifdef RTC_XFER_CMD_EN
            CMD:   state_n = WAIT;
`endif
            ISSUE: state_n = WAIT;
            WAIT:  if (bus_done) state_n = NEXT;
            NEXT: begin
`ifdef RTC_XFER_CMD_EN
                if (cmd_phase) begin
                    state_n = is_wr ? DONE : ISSUE;
                end else if (idx == LAST) begin
                    state_n = is_wr ? CMD : DONE;
                end else begin
                    state_n  = ISSUE;
                    load_idx = idx + 4'd1;
                end
`else
                if (idx == LAST) begin
                    state_n = DONE;
                end else begin
                    state_n  = ISSUE;
                    load_idx = idx + 4'd1;
                end
`endif
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // From IDLE the burst type is not registered yet, so take it from the arbiter.
    assign op_wr = (state == IDLE) ? leave_wr : is_wr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_rd   <= 1'b0;
            pend_wr   <= 1'b0;
            is_wr     <= 1'b0;
            idx       <= 4'd0;
            bus_start <= 1'b0;
            bus_rw    <= 1'b0;
            bus_addr  <= 8'h00;
            bus_wdata <= 8'h00;
            rd_valid  <= 1'b0;
            wr_done   <= 1'b0;
            busy      <= 1'b0;
`ifdef RTC_XFER_CMD_EN
            cmd_phase <= 1'b0;
`endif
            for (int i = 0; i < 9; i++) begin
                snap[i]   <= 8'h00;
                shadow[i] <= 8'h00;
                rd_q[i]   <= 8'h00;
            end
        end else begin
            bus_start <= 1'b0;
            rd_valid  <= 1'b0;
            wr_done   <= 1'b0;
            busy      <= (state_n != IDLE);
            pend_rd   <= (pend_rd & ~leave_rd) | tick_lectura;
            pend_wr   <= (pend_wr & ~leave_wr) | escribe_req;

            if (leave_rd || leave_wr) begin
                is_wr <= leave_wr;
                idx   <= 4'd0;
            end
            if (leave_wr)
                for (int i = 0; i < 9; i++) snap[i] <= wr_in[i];

            if (state_n == ISSUE && state != ISSUE) begin
                idx       <= load_idx;
                bus_start <= 1'b1;
                bus_rw    <= ~op_wr;
                bus_addr  <= reg_addr(load_idx);
                if (!op_wr)             bus_wdata <= 8'h00;
                else if (state == IDLE) bus_wdata <= wr_in[load_idx];
                else                    bus_wdata <= snap[load_idx];
            end

`ifdef RTC_XFER_CMD_EN
            if (state == NEXT) cmd_phase <= 1'b0;
            if (state_n == CMD && state != CMD) begin
                bus_start <= 1'b1;
                bus_rw    <= 1'b0;
                bus_addr  <= (state == IDLE) ? 8'hF0 : 8'hF1;
                bus_wdata <= (state == IDLE) ? 8'hF0 : 8'hF1;
                cmd_phase <= 1'b1;
            end
            if (state == WAIT && bus_done && !is_wr && !cmd_phase)
                shadow[idx] <= bus_rdata;
`else
            if (state == WAIT && bus_done && !is_wr)
                shadow[idx] <= bus_rdata;
`endif

            // Whole set copied at once so rd_* never shows a mix of two bursts.
            if (state_n == DONE && state != DONE) begin
                if (is_wr) begin
                    wr_done <= 1'b1;
                end else begin
                    rd_valid <= 1'b1;
                    for (int i = 0; i < 9; i++) rd_q[i] <= shadow[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_rtc_bus_sched.sv
// Scoreboard bench for rtc_bus_sched: RTC memory model behind a 3-cycle driver, expected bursts queued at stimulus time.
module tb_rtc_bus_sched;
    logic clk = 1'b0;
    logic reset;
    logic tick_lectura, escribe_req;
    logic [8:0][7:0] wr_all;
    logic bus_done;
    logic [7:0] bus_rdata;
    logic bus_start, bus_rw;
    logic [7:0] bus_addr, bus_wdata;
    logic [7:0] rd_seg_C, rd_min_C, rd_hora_C, rd_dia, rd_mes, rd_ano, rd_seg_T, rd_min_T, rd_hora_T;
    logic rd_valid, wr_done, busy;
    logic [8:0][7:0] rd_all;

    assign rd_all = {rd_hora_T, rd_min_T, rd_seg_T, rd_ano, rd_mes, rd_dia, rd_hora_C, rd_min_C, rd_seg_C};

    rtc_bus_sched dut (
        .clk(clk), .reset(reset),
        .tick_lectura(tick_lectura), .escribe_req(escribe_req),
        .wr_seg_C(wr_all[0]), .wr_min_C(wr_all[1]), .wr_hora_C(wr_all[2]),
        .wr_dia(wr_all[3]), .wr_mes(wr_all[4]), .wr_ano(wr_all[5]),
        .wr_seg_T(wr_all[6]), .wr_min_T(wr_all[7]), .wr_hora_T(wr_all[8]),
        .bus_done(bus_done), .bus_rdata(bus_rdata),
        .bus_start(bus_start), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .rd_seg_C(rd_seg_C), .rd_min_C(rd_min_C), .rd_hora_C(rd_hora_C),
        .rd_dia(rd_dia), .rd_mes(rd_mes), .rd_ano(rd_ano),
        .rd_seg_T(rd_seg_T), .rd_min_T(rd_min_T), .rd_hora_T(rd_hora_T),
        .rd_valid(rd_valid), .wr_done(wr_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [7:0] addr; logic rw; logic [7:0] wdata; logic first;} txn_t;
    typedef struct packed {logic is_wr; logic [8:0][7:0] v;} cpl_t;

    localparam logic [7:0] AMAP [0:8] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

    txn_t exp_q[$];
    cpl_t cpl_q[$];
    logic [8:0][7:0] img;      // RTC contents as the model expects them after queued bursts
    logic [7:0] mem [256];     // RTC contents as the driver model holds them
    int n_cmp = 0, n_bad = 0, n_starts = 0, cyc = 0, last_done = -100;
    logic inflight = 1'b0, h_rw;
    logic [7:0] h_addr, h_wdata;
    logic [8:0][7:0] cur_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag_bad(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Driver model: done 3 cycles after start, reads return memory, writes update it.
    logic [7:0] d_addr, d_wdata;
    logic d_rw;
    int d_cnt = 0;
    initial begin
        bus_done = 1'b0;
        bus_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            bus_done = 1'b0;
            if (reset) begin
                d_cnt = 0;
            end else begin
                if (d_cnt > 0) begin
                    d_cnt--;
                    if (d_cnt == 0) begin
                        bus_done = 1'b1;
                        bus_rdata = d_rw ? mem[d_addr] : 8'h00;
                        if (!d_rw) mem[d_addr] = d_wdata;
                    end
                end
                if (bus_start) begin
                    d_addr = bus_addr; d_rw = bus_rw; d_wdata = bus_wdata; d_cnt = 3;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT launches a transaction or completes a burst.
    always @(negedge clk) begin
        txn_t e;
        cpl_t c;
        if (!reset) begin
            if (inflight) chk("bus_hold", {h_addr, h_rw, h_wdata}, {bus_addr, bus_rw, bus_wdata});
            if (bus_done) begin
                inflight = 1'b0;
                last_done = cyc;
            end
            if (bus_start) begin
                n_starts++;
                if (exp_q.size() == 0) begin
                    flag_bad($sformatf("unexpected_start addr=%0h", bus_addr));
                end else begin
                    e = exp_q.pop_front();
                    chk("txn_addr", bus_addr, e.addr);
                    chk("txn_rw", bus_rw, e.rw);
                    if (!e.rw) chk("txn_wdata", bus_wdata, e.wdata);
                    if (!e.first) chk("start_gap", cyc - last_done, 2);
                end
                h_addr = bus_addr; h_rw = bus_rw; h_wdata = bus_wdata;
                inflight = 1'b1;
            end
            if (rd_valid || wr_done) begin
                if (cpl_q.size() == 0) begin
                    flag_bad("unexpected_completion");
                end else begin
                    c = cpl_q.pop_front();
                    chk("cpl_kind", {rd_valid, wr_done}, c.is_wr ? 2'b01 : 2'b10);
                    if (!c.is_wr) chk("rd_set", rd_all, c.v);
                    chk("cpl_gap", cyc - last_done, 2);
                end
            end
            if (rd_valid) cur_rd = rd_all;
            else chk("rd_stable", rd_all, cur_rd);
        end
    end

    task automatic push_read();
        txn_t t;
        cpl_t c;
`ifdef RTC_XFER_CMD_EN
        t.addr = 8'hF0; t.rw = 1'b0; t.wdata = 8'hF0; t.first = 1'b1;
        exp_q.push_back(t);
`endif
        for (int i = 0; i < 9; i++) begin
            t.addr = AMAP[i]; t.rw = 1'b1; t.wdata = 8'h00;
`ifdef RTC_XFER_CMD_EN
            t.first = 1'b0;
`else
            t.first = (i == 0);
`endif
            exp_q.push_back(t);
        end
        c.is_wr = 1'b0; c.v = img;
        cpl_q.push_back(c);
    endtask

    task automatic push_write(input logic [8:0][7:0] vals);
        txn_t t;
        cpl_t c;
        for (int i = 0; i < 9; i++) begin
            t.addr = AMAP[i]; t.rw = 1'b0; t.wdata = vals[i]; t.first = (i == 0);
            exp_q.push_back(t);
        end
`ifdef RTC_XFER_CMD_EN
        t.addr = 8'hF1; t.rw = 1'b0; t.wdata = 8'hF1; t.first = 1'b0;
        exp_q.push_back(t);
`endif
        img = vals;
        c.is_wr = 1'b1; c.v = vals;
        cpl_q.push_back(c);
    endtask

    function automatic logic [8:0][7:0] rand_set();
        logic [8:0][7:0] r;
        for (int i = 0; i < 9; i++) r[i] = 8'($urandom_range(0, 255));
        return r;
    endfunction

    task automatic pulse(input logic rd, input logic wr, output int t);
        @(posedge clk);
        #1;
        tick_lectura = rd;
        escribe_req = wr;
        t = cyc;
        @(posedge clk);
        #1;
        tick_lectura = 1'b0;
        escribe_req = 1'b0;
    endtask

    task automatic wait_first_start(input int t, input string nm);
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus_start) break;
        end
        if (k == 20) flag_bad({nm, "_timeout"});
        else chk(nm, cyc - t, 2);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0 && cpl_q.size() == 0) break;
        end
        if (k == 3000) flag_bad("idle_timeout");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, k, gap, base, op;
        logic [8:0][7:0] vals;
        reset = 1'b1;
        tick_lectura = 1'b0;
        escribe_req = 1'b0;
        wr_all = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 9; i++) begin
            mem[AMAP[i]] = 8'h10 + 8'(i);
            img[i] = 8'h10 + 8'(i);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {bus_start, bus_rw, bus_addr, bus_wdata, rd_valid, wr_done, busy}, '0);
        chk("reset_rd", rd_all, '0);
        #1 reset = 1'b0;

        // Plain refresh read: 0x10..0x18 expected, first start two cycles after the pulse.
        push_read();
        pulse(1'b1, 1'b0, t);
        wait_first_start(t, "read_latency");
        wait_idle();

        // Write snapshot: inputs change after the burst has started.
        vals = rand_set();
        vals[0] = 8'h45;
        wr_all = vals;
        push_write(vals);
        pulse(1'b0, 1'b1, t);
        wait_first_start(t, "write_latency");
        @(posedge clk);
        #1 wr_all = rand_set();
        wr_all[0] = 8'h00;
        wait_idle();

        // Simultaneous requests: write then read, one idle cycle between.
        vals = rand_set();
        wr_all = vals;
        push_write(vals);
        push_read();
        pulse(1'b1, 1'b1, t);
        for (k = 0; k < 500; k++) begin
            @(negedge clk);
            if (wr_done) break;
        end
        if (k == 500) flag_bad("wr_done_timeout");
        gap = 0;
        repeat (4) begin
            @(negedge clk);
            if (!busy) gap++;
        end
        chk("idle_gap", gap, 1);
        wait_idle();

        // Merging: three read pulses during a write burst give one read burst.
        vals = rand_set();
        wr_all = vals;
        base = n_starts;
        push_write(vals);
        push_read();
        pulse(1'b0, 1'b1, t);
        repeat (3) begin
            repeat (8) @(posedge clk);
            pulse(1'b1, 1'b0, t);
        end
        wait_idle();
        repeat (30) @(posedge clk);
`ifdef RTC_XFER_CMD_EN
        chk("merge_starts", n_starts - base, 20);
`else
        chk("merge_starts", n_starts - base, 18);
`endif

        // Randomised mix of reads, writes and simultaneous pairs.
        for (int it = 0; it < 8; it++) begin
            op = $urandom_range(0, 2);
            if (op != 0) begin
                vals = rand_set();
                wr_all = vals;
                push_write(vals);
            end
            if (op != 1) push_read();
            pulse(op != 1, op != 0, t);
            repeat (3) @(posedge clk);
            #1 wr_all = rand_set();
            wait_idle();
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end

        // Reset mid read burst with a further read pending.
        push_read();
        pulse(1'b1, 1'b0, t);
        k = 0;
        for (int n = 0; n < 200 && k < 3; n++) begin
            @(negedge clk);
            if (bus_done) k++;
        end
        if (k < 3) flag_bad("pre_reset_timeout");
        pulse(1'b1, 1'b0, t);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("midreset_ctrl", {bus_start, bus_rw, bus_addr, bus_wdata, rd_valid, wr_done, busy}, '0);
        chk("midreset_rd", rd_all, '0);
        exp_q.delete();
        cpl_q.delete();
        cur_rd = '0;
        inflight = 1'b0;
        base = n_starts;
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (40) @(posedge clk);
        chk("no_traffic_after_reset", n_starts - base, 0);

        // Recovery: a fresh read returns the memory image.
        push_read();
        pulse(1'b1, 1'b0, t);
        wait_first_start(t, "post_reset_latency");
        wait_idle();
        repeat (10) @(posedge clk);
        chk("queues_drained", exp_q.size() + cpl_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
